// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with a divide FSM and stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic              ex_div,
  input  logic              ex_branch_taken,
  input  logic              imem_ready,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_stall,
  output logic              fd_stall,
  output logic              fd_flush,
  output logic              de_stall,
  output logic              de_flush,
  output logic              em_stall,
  output logic              em_flush,
  output logic              mw_stall,
  output logic              mw_flush,
  output logic              div_busy,
  output logic              div_done,
  output logic [PERF_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [PERF_W-1:0] r_stall_cycles;
  logic w_mem_wait, w_div_stall, w_load_use, w_imem_wait;
  assign w_mem_wait  = dmem_req & ~dmem_ready;
  assign w_div_stall = ((r_state == IDLE) & ex_div) | (r_state == BUSY);
  assign w_load_use  = ex_mem_read & (ex_rd != 5'd0) &
                       ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
  assign w_imem_wait = ~imem_ready;
  assign div_busy     = (r_state == BUSY);
  assign div_done     = (r_state == DONE);
  assign stall_cycles = r_stall_cycles;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  // The divider keeps counting under a data-memory wait; only IDLE entry and DONE exit wait for it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (ex_div & ~w_mem_wait) begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
      end
      DONE: if (!w_mem_wait) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_comb begin
    pc_stall = 1'b0;
    fd_stall = 1'b0;
    fd_flush = 1'b0;
    de_stall = 1'b0;
    de_flush = 1'b0;
    em_stall = 1'b0;
    em_flush = 1'b0;
    mw_stall = 1'b0;
    mw_flush = 1'b0;
    if (rst_n) begin
      if (w_mem_wait) begin
        {pc_stall, fd_stall, de_stall, em_stall} = 4'hF;
        mw_flush = 1'b1;
      end else if (w_div_stall) begin
        {pc_stall, fd_stall, de_stall} = 3'h7;
        em_flush = 1'b1;
      end else if (ex_branch_taken) begin
        {fd_flush, de_flush} = 2'h3;
      end else if (w_load_use) begin
        {pc_stall, fd_stall, de_flush} = 3'h7;
      end else if (w_imem_wait) begin
        {pc_stall, fd_flush} = 2'h3;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_stall_cycles <= '0;
    else if (pc_stall && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 1'b1;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for the hazard sequencer (DIV_CYCLES=8, PERF_W=4).
module tb_pipeline_hazard_ctrl;
  localparam logic [10:0] PC = 11'h400, FDS = 11'h200, FDF = 11'h100, DES = 11'h080, DEF = 11'h040;
  localparam logic [10:0] EMS = 11'h020, EMF = 11'h010, MWF = 11'h004, BSY = 11'h002, DN = 11'h001;
  localparam logic [10:0] E_LU  = PC | FDS | DEF;
  localparam logic [10:0] E_DIV = PC | FDS | DES | EMF;
  localparam logic [10:0] E_MEM = PC | FDS | DES | EMS | MWF;
  localparam logic [10:0] E_BR  = FDF | DEF;
  localparam logic [10:0] E_IM  = PC | FDF;
  logic clk, rst_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic id_use_rs, id_use_rt, ex_mem_read, ex_div, ex_branch_taken, imem_ready, dmem_req, dmem_ready;
  logic pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_stall, mw_flush;
  logic div_busy, div_done;
  logic [3:0] stall_cycles;
  logic [10:0] obs;
  logic [14:0] exp_q[$];
  logic [14:0] e;
  logic [3:0] m_cnt;
  int checks = 0, errors = 0;
  pipeline_hazard_ctrl #(.DIV_CYCLES(8), .CNT_W(6), .PERF_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_div(ex_div), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush), .de_stall(de_stall), .de_flush(de_flush),
    .em_stall(em_stall), .em_flush(em_flush), .mw_stall(mw_stall), .mw_flush(mw_flush),
    .div_busy(div_busy), .div_done(div_done), .stall_cycles(stall_cycles)
  );
  assign obs = {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_stall, mw_flush,
                div_busy, div_done};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; ex_div = 1'b0; ex_branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask
  // Expected entry carries the counter value visible this cycle; the model then advances on a stall.
  task automatic push(input logic [10:0] x);
    exp_q.push_back({m_cnt, x});
    if (x[10] && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    m_cnt = 4'd0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    m_cnt = 4'd0;
    exp_q.delete();
    push(11'h0);
    #2;
    e = exp_q.pop_front();
    checks++; if (obs !== e[10:0]) begin errors++; $display("FAIL reset outputs=%b expected=%b", obs, e[10:0]); end
    checks++; if (stall_cycles !== e[14:11]) begin errors++; $display("FAIL reset_cnt stall_cycles=%0d expected=%0d", stall_cycles, e[14:11]); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic test_load_use();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c == 0) begin ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1; push(E_LU); end
      else if (c == 2) begin ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1; push(11'h0); end
      else if (c == 3) begin ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_use_rt = 1; push(E_LU); end
      else if (c == 4) begin ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_use_rt = 0; push(11'h0); end
      else if (c == 5) begin ex_mem_read = 0; ex_rd = 5; id_rs = 5; id_use_rs = 1; push(11'h0); end
      else push(11'h0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (obs !== e[10:0]) begin errors++; $display("FAIL load_use c=%0d outputs=%b expected=%b", c, obs, e[10:0]); end
      checks++; if (stall_cycles !== e[14:11]) begin errors++; $display("FAIL load_use_cnt c=%0d stall_cycles=%0d expected=%0d", c, stall_cycles, e[14:11]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_branch();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      if (c < 4) ex_branch_taken = 1'b1;
      if (c == 0) begin ex_mem_read = 1; ex_rd = 9; id_rs = 9; id_use_rs = 1; push(E_BR); end
      else if (c == 1) push(E_BR);
      else if (c == 2) begin imem_ready = 0; push(E_BR); end
      else if (c == 3) begin dmem_req = 1; push(E_MEM); end
      else push(11'h0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (obs !== e[10:0]) begin errors++; $display("FAIL branch c=%0d outputs=%b expected=%b", c, obs, e[10:0]); end
      checks++; if (stall_cycles !== e[14:11]) begin errors++; $display("FAIL branch_cnt c=%0d stall_cycles=%0d expected=%0d", c, stall_cycles, e[14:11]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_imem_wait(input int n, input string name);
    do_reset();
    for (int c = 0; c <= n; c++) begin
      idle_inputs();
      if (c < n) begin imem_ready = 1'b0; push(E_IM); end
      else push(11'h0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (obs !== e[10:0]) begin errors++; $display("FAIL %s c=%0d outputs=%b expected=%b", name, c, obs, e[10:0]); end
      checks++; if (stall_cycles !== e[14:11]) begin errors++; $display("FAIL %s_cnt c=%0d stall_cycles=%0d expected=%0d", name, c, stall_cycles, e[14:11]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_divide();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      ex_div = (c <= 8);
      push(c == 0 ? E_DIV : c <= 7 ? (E_DIV | BSY) : c == 8 ? DN : 11'h0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (obs !== e[10:0]) begin errors++; $display("FAIL divide c=%0d outputs=%b expected=%b", c, obs, e[10:0]); end
      checks++; if (stall_cycles !== e[14:11]) begin errors++; $display("FAIL divide_cnt c=%0d stall_cycles=%0d expected=%0d", c, stall_cycles, e[14:11]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_div_mem_wait();
    do_reset();
    for (int c = 0; c < 17; c++) begin
      idle_inputs();
      ex_div = (c <= 15);
      dmem_req = (c >= 3 && c <= 15);
      dmem_ready = (c == 15);
      push((c >= 3 && c <= 14) ? (E_MEM | (c <= 7 ? BSY : DN)) :
           c == 0 ? E_DIV : c <= 2 ? (E_DIV | BSY) : c == 15 ? DN : 11'h0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (obs !== e[10:0]) begin errors++; $display("FAIL div_mem c=%0d outputs=%b expected=%b", c, obs, e[10:0]); end
      checks++; if (stall_cycles !== e[14:11]) begin errors++; $display("FAIL div_mem_cnt c=%0d stall_cycles=%0d expected=%0d", c, stall_cycles, e[14:11]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_mid_div();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      if (c == 3) begin
        rst_n = 1'b0;
        m_cnt = 4'd0;
        push(11'h0);
        #1;
      end else begin
        ex_div = (c <= 2);
        dmem_req = (c == 0);
        push(c == 0 ? E_MEM : c == 1 ? E_DIV : c == 2 ? (E_DIV | BSY) : 11'h0);
        @(negedge clk);
      end
      e = exp_q.pop_front();
      checks++; if (obs !== e[10:0]) begin errors++; $display("FAIL reset_div c=%0d outputs=%b expected=%b", c, obs, e[10:0]); end
      checks++; if (stall_cycles !== e[14:11]) begin errors++; $display("FAIL reset_div_cnt c=%0d stall_cycles=%0d expected=%0d", c, stall_cycles, e[14:11]); end
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
  endtask
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    m_cnt = 4'd0;
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_imem_wait(3, "imem");
    test_imem_wait(20, "saturate");
    test_divide();
    test_div_mem_wait();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). It drives the stall and flush inputs of the four inter-stage registers (fetch2dec, dec2exec, exec2mem, mem2wb) and the PC hold. It resolves load-use hazards, taken branches, multi-cycle divide occupancy, and instruction/data memory wait states. It also keeps a saturating stall-cycle performance counter.

Parameters:
DIV_CYCLES, 8, total EX-stall cycles per divide; legal values are 2 to 2^CNT_W-1.
CNT_W, 6, width of the divide cycle counter.
PERF_W, 32, width of the stall-cycle counter.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
ex_mem_read  in  1  EX instruction is a load
ex_rd  in  5  destination register of the EX instruction
ex_div  in  1  EX instruction is DIV/DIVU
ex_branch_taken  in  1  branch/jump resolved taken in EX
imem_ready  in  1  instruction fetch data valid this cycle
dmem_req  in  1  MEM stage access in progress
dmem_ready  in  1  data memory completes this cycle
pc_stall  out  1  hold the PC
fd_stall, fd_flush  out  1 each  control for fetch2dec
de_stall, de_flush  out  1 each  control for dec2exec
em_stall, em_flush  out  1 each  control for exec2mem
mw_stall, mw_flush  out  1 each  control for mem2wb
div_busy  out  1  divider occupying EX
div_done  out  1  one-cycle pulse: divide result valid, EX advances
stall_cycles  out  PERF_W  saturating count of cycles with pc_stall=1

Behaviour:
Reset: all outputs are 0, the FSM is in IDLE, and the divide counter is 0. Reset is legal mid-divide and mid-wait; after reset the block returns directly to IDLE.
Stage registers ignore flush while their stall is high. This block therefore never asserts flushX and stallX together on the same register.
Internal hazard conditions (all combinational):
- mem_wait = dmem_req & ~dmem_ready.
- div_stall = (state==IDLE & ex_div) | state==BUSY.
- load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- imem_wait = ~imem_ready.
Priority, highest first. Only the highest active condition drives the outputs; every output not listed is 0.
1. mem_wait: pc/fd/de/em stall = 1; mw_flush = 1.
2. div_stall: pc/fd/de stall = 1; em_flush = 1.
3. ex_branch_taken: fd_flush = 1 and de_flush = 1. The PC is not stalled, so it loads the target.
4. load_use: pc_stall = 1 and fd_stall = 1; de_flush = 1 (bubble into EX).
5. imem_wait: pc_stall = 1; fd_flush = 1 (bubble into ID).
Branch is ranked above load_use because the ID instruction is on the wrong path.
Divide FSM (registered; states IDLE, BUSY, DONE):
- IDLE: if ex_div & ~mem_wait, load cnt = DIV_CYCLES-1 and go to BUSY. If mem_wait, stay in IDLE without loading.
- BUSY: div_busy = 1; cnt decrements every cycle, regardless of mem_wait. When cnt==1, go to DONE.
- DONE: div_done = 1 and div_stall = 0. If mem_wait, remain in DONE with div_done held. Otherwise go to IDLE.
- In DONE, ex_div is ignored, because the same divide is still in EX while it advances.
- Net effect with no mem_wait: exactly DIV_CYCLES stalled cycles, then one DONE cycle in which EX advances.
- ex_div in EX and ex_branch_taken are mutually exclusive by decode. If both are seen, div wins.
stall_cycles: increments on every clock edge where pc_stall = 1. It saturates at 2^PERF_W-1 and does not wrap.
Latency: all stall and flush outputs are combinational from their inputs and the FSM state, with zero cycles of latency.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_use_rs=1 for one cycle -> pc_stall=fd_stall=de_flush=1 for 1 cycle; stall_cycles 0 to 1. With ex_rd=0 -> no stall.
- Divide with DIV_CYCLES=8: ex_div=1 held -> pc/fd/de_stall=1 and em_flush=1 for exactly 8 cycles, div_busy high for 7 cycles, then a div_done pulse of 1 cycle, then IDLE.
- Mem wait during divide: dmem_req=1 and dmem_ready=0 for 12 cycles starting at divide cycle 3 -> em_stall=1 and mw_flush=1 throughout, em_flush=0. The FSM reaches DONE and holds div_done until dmem_ready=1, then returns to IDLE.
- Branch vs load-use: ex_branch_taken=1 while a load-use condition is present -> fd_flush=de_flush=1, pc_stall=0, fd_stall=0.
- imem wait: imem_ready=0 for 3 cycles -> pc_stall=1 and fd_flush=1 for 3 cycles; stall_cycles increases by 3.
- Reset and saturation: assert rst_n=0 in BUSY -> outputs go to 0 asynchronously and the FSM is in IDLE. With PERF_W=4, 20 stalled cycles -> stall_cycles=15.
